scarv_soc_bram_copy: RTL and testbench
======================================

Name: scarv_soc_bram_copy

Overview:
- Word-granular copy engine that acts as initiator on both ports of the SoC dual-port BRAM.
- Reads consecutive words through port A and writes them through port B.
- Sustains one word per cycle after a one-cycle fill.
- Used for boot-time image relocation and memory clearing/test inside the SoC; controlled by a simple start/done handshake from a CPU-facing register block.

Parameters:
- DEPTH, 1024, BRAM depth in bytes; must match the attached BRAM.
- LW, $clog2(DEPTH), byte address width (derived, localparam).
- LEN_W, 16, width of the word-count field.

Ports:
- g_clk      in   1      system clock
- g_resetn   in   1      synchronous active-low reset
- start      in   1      1-cycle request pulse; sampled only in IDLE
- abort      in   1      stop issuing reads; sampled in RUN
- src_addr   in   LW     source byte address, word aligned
- dst_addr   in   LW     destination byte address, word aligned
- len        in   LEN_W  number of 32-bit words to copy
- busy       out  1      copy in progress
- done       out  1      1-cycle completion pulse
- err        out  1      valid with done: misaligned address
- aborted    out  1      valid with done: copy terminated by abort
- ena        out  1      port A enable
- wea        out  4      port A byte write enables, tied 4'h0
- addra      out  LW     port A byte address
- douta      in   32     port A read data, valid the cycle after ena
- enb        out  1      port B enable
- web        out  4      port B byte write enables
- addrb      out  LW     port B byte address
- dinb       out  32     port B write data

Behaviour:
- Reset (g_resetn low at a posedge) returns the FSM to IDLE and clears outputs. Takes effect mid-copy too; an in-flight write is dropped.
  - busy, done, err, aborted, ena, enb = 0
  - addra, addrb = 0; web = 0; dinb = 0
- All outputs are registered except dinb, which is driven from douta whenever enb is high and 0 otherwise.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 captures src_addr, dst_addr and len into internal regs.
  - If src_addr[1:0] or dst_addr[1:0] is nonzero: go to DONE with err=1. No port access occurs.
  - Else if len==0: go to DONE. No port access occurs.
  - Else: go to RUN.
- RUN (cycle k = 1..len after start):
  - ena=1, addra = src + 4*(k-1), modulo DEPTH (wraps to 0 past DEPTH-4).
  - remaining-count decrements each cycle.
  - After the final read, go to DRAIN.
  - abort=1 in RUN: the read issued in that cycle is the last one; go to DRAIN with aborted flag set.
- Write side (lagging reads by one cycle, states RUN and DRAIN):
  - In each cycle following a read, enb=1, web=4'hF, addrb = dst + 4*(j), with j = index of the previous read.
  - addrb wraps modulo DEPTH.
  - dinb = douta.
- DRAIN: performs the final write only (ena=0), then goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0, err/aborted reflect the result; then IDLE.
  - err and aborted hold their values until the next start is accepted.
- busy: high from the cycle after start through the DRAIN cycle.
  - For len=N with no abort: busy high for N+1 cycles; done at cycle N+2 after the start cycle.
- start while busy is ignored. abort outside RUN is ignored.
- Address arithmetic is LW bits wide; carry out is discarded.
- Overlap:
  - src==dst is legal; data is unchanged.
  - dst in (src, src+4*len) is undefined, because port A reads collide with port B writes; this is the caller's responsibility.
- No write ever issues without a matching read in the previous cycle. Writes = reads executed.

Test Plan:
- Basic copy: BRAM word 0x000..0x00C preloaded {11111111,22222222,33333333,44444444}; start src=0x000 dst=0x100 len=4.
  - ena high cycles 1-4; enb high cycles 2-5.
  - done at cycle 6.
  - 0x100..0x10C hold the same words; err=0.
- Zero length: start len=0 -> done at cycle 1, busy never high, ena=enb=0 throughout, err=0.
- Misaligned: start src=0x002 len=3 -> done at cycle 1 with err=1, no port activity. A following valid start clears err.
- Wrap: start src=0x3F8 dst=0x000 len=4.
  - addra sequence 3F8,3FC,000,004.
  - addrb sequence 000,004,008,00C.
- Abort: start len=10, abort asserted in cycle 3.
  - Exactly 3 reads and 3 writes occur; done at cycle 5 with aborted=1.
  - Destination words 3..9 are untouched.
- Reset mid-copy: g_resetn low at cycle 3 of a len=8 copy.
  - Next cycle all outputs are 0 and the FSM is in IDLE.
  - A new start then runs normally.

Source files
------------

// File: rtl/scarv_soc_bram_copy.sv
// -----------------------------------------------------------------------------
// scarv_soc_bram_copy
//
// Word-granular copy engine. It drives both ports of the SoC dual-port BRAM
// as initiator: port A reads consecutive source words, and port B writes them
// to the destination one cycle later. After a one-cycle fill it moves one
// 32-bit word per cycle. A CPU-facing register block controls it with a
// start/done handshake.
//
// Ports
//   g_clk, g_resetn        clock, synchronous active-low reset
//   start                  1-cycle request pulse, only honoured in IDLE
//   abort                  stop issuing reads (honoured in RUN only)
//   src_addr, dst_addr     word-aligned byte addresses
//   len                    number of 32-bit words to copy
//   busy                   copy in progress
//   done                   1-cycle completion pulse
//   err, aborted           result flags, valid with done, held until next start
//   ena/wea/addra/douta    BRAM port A (read only, wea tied to zero)
//   enb/web/addrb/dinb     BRAM port B (write only)
// -----------------------------------------------------------------------------
module scarv_soc_bram_copy #(
  parameter  int DEPTH = 1024,
  parameter  int LEN_W = 16,
  localparam int LW    = $clog2(DEPTH)
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [LW-1:0]    src_addr,
  input  logic [LW-1:0]    dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted,
  output logic             ena,
  output logic [3:0]       wea,
  output logic [LW-1:0]    addra,
  input  logic [31:0]      douta,
  output logic             enb,
  output logic [3:0]       web,
  output logic [LW-1:0]    addrb,
  output logic [31:0]      dinb
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_reg,     state_next;
  logic             busy_reg,      busy_next;
  logic             done_reg,      done_next;
  logic             err_reg,       err_next;
  logic             aborted_reg,   aborted_next;
  logic             ena_reg,       ena_next;
  logic [LW-1:0]    addra_reg,     addra_next;
  logic             enb_reg,       enb_next;
  logic [3:0]       web_reg,       web_next;
  logic [LW-1:0]    addrb_reg,     addrb_next;
  // Destination address of the write that follows the read now on port A.
  logic [LW-1:0]    wr_addr_reg,   wr_addr_next;
  // Reads still to issue after the one currently presented on port A.
  logic [LEN_W-1:0] remaining_reg, remaining_next;

  logic misaligned;
  assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

  always_comb begin
    state_next     = state_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    err_next       = err_reg;
    aborted_next   = aborted_reg;
    ena_next       = ena_reg;
    addra_next     = addra_reg;
    enb_next       = enb_reg;
    web_next       = web_reg;
    addrb_next     = addrb_reg;
    wr_addr_next   = wr_addr_reg;
    remaining_next = remaining_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          err_next       = misaligned;
          aborted_next   = 1'b0;
          addra_next     = src_addr;
          wr_addr_next   = dst_addr;
          remaining_next = len - LEN_W'(1);
          if (misaligned || (len == '0)) begin
            // Nothing to move: report straight away without touching the BRAM.
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = RUN;
            busy_next  = 1'b1;
            ena_next   = 1'b1;
          end
        end
      end

      RUN: begin
        // Every cycle in RUN has a read on port A, so the next cycle always
        // carries the matching write on port B.
        enb_next     = 1'b1;
        web_next     = 4'hF;
        addrb_next   = wr_addr_reg;
        wr_addr_next = wr_addr_reg + LW'(4);
        if (abort || (remaining_reg == '0)) begin
          state_next   = DRAIN;
          ena_next     = 1'b0;
          aborted_next = abort;
        end else begin
          addra_next     = addra_reg + LW'(4);
          remaining_next = remaining_reg - LEN_W'(1);
        end
      end

      DRAIN: begin
        // The last write is on port B during this cycle.
        state_next = DONE;
        enb_next   = 1'b0;
        web_next   = 4'h0;
        busy_next  = 1'b0;
        done_next  = 1'b1;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      aborted_reg   <= 1'b0;
      ena_reg       <= 1'b0;
      addra_reg     <= '0;
      enb_reg       <= 1'b0;
      web_reg       <= 4'h0;
      addrb_reg     <= '0;
      wr_addr_reg   <= '0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      aborted_reg   <= aborted_next;
      ena_reg       <= ena_next;
      addra_reg     <= addra_next;
      enb_reg       <= enb_next;
      web_reg       <= web_next;
      addrb_reg     <= addrb_next;
      wr_addr_reg   <= wr_addr_next;
      remaining_reg <= remaining_next;
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign err     = err_reg;
  assign aborted = aborted_reg;
  assign ena     = ena_reg;
  assign wea     = 4'h0;
  assign addra   = addra_reg;
  assign enb     = enb_reg;
  assign web     = web_reg;
  assign addrb   = addrb_reg;
  // Read data from the previous cycle's read flows straight through to port B.
  assign dinb    = enb_reg ? douta : 32'h0;

endmodule

// File: tb/tb_scarv_soc_bram_copy.sv
// -----------------------------------------------------------------------------
// tb_scarv_soc_bram_copy
//
// Bench for scarv_soc_bram_copy with a behavioural dual-port BRAM attached.
// Each copy request queues its expected port A reads, port B writes and done
// event. A monitor branch pops and compares them as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_scarv_soc_bram_copy;

  localparam int DEPTH = 1024;
  localparam int LW    = 10;
  localparam int LEN_W = 16;
  localparam int WORDS = DEPTH / 4;

  logic             g_clk    = 1'b0;
  logic             g_resetn = 1'b0;
  logic             start    = 1'b0;
  logic             abort    = 1'b0;
  logic [LW-1:0]    src_addr = '0;
  logic [LW-1:0]    dst_addr = '0;
  logic [LEN_W-1:0] len      = '0;
  logic             busy, done, err, aborted, ena, enb;
  logic [3:0]       wea, web;
  logic [LW-1:0]    addra, addrb;
  logic [31:0]      douta, dinb;

  always #5 g_clk = ~g_clk;

  scarv_soc_bram_copy #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .start   (start),
    .abort   (abort),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .aborted (aborted),
    .ena     (ena),
    .wea     (wea),
    .addra   (addra),
    .douta   (douta),
    .enb     (enb),
    .web     (web),
    .addrb   (addrb),
    .dinb    (dinb)
  );

  // Behavioural BRAM with a preload port so only this block writes mem.
  logic [31:0] mem [WORDS];
  logic        pl_we   = 1'b0;
  logic [7:0]  pl_idx  = '0;
  logic [31:0] pl_data = '0;

  always @(posedge g_clk) begin
    if (ena) douta <= mem[addra[LW-1:2]];
    if (enb) begin
      for (int b = 0; b < 4; b++)
        if (web[b]) mem[addrb[LW-1:2]][8*b +: 8] <= dinb[8*b +: 8];
    end
    if (pl_we) mem[pl_idx] <= pl_data;
  end

  int cyc = 0;
  always @(posedge g_clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [LW-1:0] addr;
    logic [31:0]   data;
  } ev_t;

  typedef struct {
    int   cyc;
    logic err;
    logic ab;
  } dn_t;

  ev_t exp_rd[$];
  ev_t exp_wr[$];
  dn_t exp_dn[$];

  logic [31:0] ref_mem [WORDS];
  int chk_cnt   = 0;
  int pass_cnt  = 0;
  int done_cnt  = 0;
  int busy_from = 1;
  int busy_to   = 0;
  logic mon_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic monitor_loop();
    ev_t e;
    dn_t d;
    forever begin
      @(negedge g_clk);
      if (mon_en) begin
        check("busy", {31'b0, busy}, {31'b0, (cyc >= busy_from) && (cyc <= busy_to)});
        if (ena) begin
          check("wea", {28'b0, wea}, 32'h0);
          if (exp_rd.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_rd.pop_front();
            check("rd_addr", {22'b0, addra}, {22'b0, e.addr});
            check("rd_cycle", cyc, e.cyc);
          end
        end
        if (enb) begin
          check("web", {28'b0, web}, 32'hF);
          if (exp_wr.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_wr.pop_front();
            check("wr_addr", {22'b0, addrb}, {22'b0, e.addr});
            check("wr_data", dinb, e.data);
            check("wr_cycle", cyc, e.cyc);
          end
        end else begin
          check("dinb_idle", dinb, 32'h0);
        end
        if (done) begin
          done_cnt++;
          if (exp_dn.size() == 0) check("done_unexpected", 32'd1, 32'd0);
          else begin
            d = exp_dn.pop_front();
            check("done_cycle", cyc, d.cyc);
            check("done_err", {31'b0, err}, {31'b0, d.err});
            check("done_aborted", {31'b0, aborted}, {31'b0, d.ab});
          end
        end
      end
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    pl_we   = 1'b1;
    pl_idx  = idx[7:0];
    pl_data = data;
    ref_mem[idx] = data;
    @(posedge g_clk); #1;
    pl_we = 1'b0;
  endtask

  // Issue one copy. abort_at / reset_at are cycle numbers after the start
  // cycle (0 = not used).
  task automatic run_copy(input logic [LW-1:0] src, input logic [LW-1:0] dst,
                          input int n_len, input int abort_at, input int reset_at);
    int s, n, target;
    logic mis, ab, seen;
    logic [31:0]   dat [64];
    logic [LW-1:0] ra  [64];
    logic [LW-1:0] wa  [64];
    ev_t e;
    dn_t d;
    @(posedge g_clk); #1;
    s      = cyc;
    target = done_cnt + 1;
    mis    = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
    ab     = (abort_at >= 1) && (abort_at <= n_len);
    n      = ab ? abort_at : n_len;
    if (mis || n_len == 0) begin
      d.cyc = s + 1; d.err = mis; d.ab = 1'b0;
      exp_dn.push_back(d);
      busy_from = 1; busy_to = 0;
      ab = 1'b0;
    end else begin
      busy_from = s + 1;
      busy_to   = s + n + 1;
      for (int k = 1; k <= n; k++) begin
        ra[k] = src + LW'(4 * (k - 1));
        wa[k] = dst + LW'(4 * (k - 1));
        // Write k-2 lands on the edge before read k samples the array.
        if (k >= 3 && (reset_at == 0 || k - 1 <= reset_at))
          ref_mem[wa[k-2][LW-1:2]] = dat[k-2];
        dat[k] = ref_mem[ra[k][LW-1:2]];
        if (reset_at == 0 || k <= reset_at) begin
          e.cyc = s + k; e.addr = ra[k]; e.data = 32'h0;
          exp_rd.push_back(e);
        end
        if (reset_at == 0 || k + 1 <= reset_at) begin
          e.cyc = s + k + 1; e.addr = wa[k]; e.data = dat[k];
          exp_wr.push_back(e);
        end
      end
      for (int j = (n >= 2 ? n - 1 : 1); j <= n; j++)
        if (reset_at == 0 || j + 1 <= reset_at) ref_mem[wa[j][LW-1:2]] = dat[j];
      if (reset_at == 0) begin
        d.cyc = s + n + 2; d.err = 1'b0; d.ab = ab;
        exp_dn.push_back(d);
      end
    end

    src_addr = src;
    dst_addr = dst;
    len      = LEN_W'(n_len);
    start    = 1'b1;
    @(posedge g_clk); #1;
    start = 1'b0;
    check("err_on_accept", {31'b0, err}, {31'b0, mis});
    check("aborted_on_accept", {31'b0, aborted}, 32'h0);

    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      abort = (abort_at > 0) && (cyc == s + abort_at);
      if (reset_at > 0 && !mis && n_len > 0) begin
        if (cyc == s + reset_at) g_resetn = 1'b0;
        else if (cyc == s + reset_at + 1) begin
          g_resetn = 1'b1;
          check("rst_busy",    {31'b0, busy},    32'h0);
          check("rst_done",    {31'b0, done},    32'h0);
          check("rst_err",     {31'b0, err},     32'h0);
          check("rst_aborted", {31'b0, aborted}, 32'h0);
          check("rst_ena",     {31'b0, ena},     32'h0);
          check("rst_enb",     {31'b0, enb},     32'h0);
          check("rst_addra",   {22'b0, addra},   32'h0);
          check("rst_addrb",   {22'b0, addrb},   32'h0);
          check("rst_web",     {28'b0, web},     32'h0);
          check("rst_dinb",    dinb,             32'h0);
          exp_rd.delete();
          exp_wr.delete();
          busy_to = s + reset_at;
          seen = 1'b1;
        end
      end else if (done_cnt >= target) seen = 1'b1;
      if (!seen) begin @(posedge g_clk); #1; end
    end
    abort = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    if (reset_at == 0) begin
      check("err_hold",     {31'b0, err},     {31'b0, mis});
      check("aborted_hold", {31'b0, aborted}, {31'b0, ab});
      check("rd_left",   exp_rd.size(), 32'd0);
      check("wr_left",   exp_wr.size(), 32'd0);
      check("done_left", exp_dn.size(), 32'd0);
    end
  endtask

  initial begin
    fork
      monitor_loop();
      begin
        // Reset held low while the BRAM is filled.
        for (int i = 0; i < WORDS; i++) preload(i, 32'hDEAD_0000 | i);
        preload(0, 32'h1111_1111);
        preload(1, 32'h2222_2222);
        preload(2, 32'h3333_3333);
        preload(3, 32'h4444_4444);
        preload(8'hFE, 32'hAAAA_AAAA);
        preload(8'hFF, 32'hBBBB_BBBB);
        for (int i = 0; i < 10; i++) preload(8'h10 + i, 32'h5000_0000 + i);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_ena",  {31'b0, ena},  32'h0);
        check("reset_enb",  {31'b0, enb},  32'h0);
        check("reset_err",  {31'b0, err},  32'h0);
        g_resetn = 1'b1;
        mon_en   = 1'b1;

        // Basic copy of four words.
        run_copy(10'h000, 10'h100, 4, 0, 0);
        check("basic_w0", mem[8'h40], 32'h1111_1111);
        check("basic_w1", mem[8'h41], 32'h2222_2222);
        check("basic_w2", mem[8'h42], 32'h3333_3333);
        check("basic_w3", mem[8'h43], 32'h4444_4444);

        // Zero length, then misaligned, then a valid start clearing err.
        run_copy(10'h000, 10'h140, 0, 0, 0);
        run_copy(10'h002, 10'h140, 3, 0, 0);
        run_copy(10'h000, 10'h180, 2, 0, 0);
        check("clr_w0", mem[8'h60], 32'h1111_1111);
        check("clr_w1", mem[8'h61], 32'h2222_2222);

        // Address wrap at the top of the BRAM.
        run_copy(10'h3F8, 10'h000, 4, 0, 0);
        check("wrap_w0", mem[8'h00], 32'hAAAA_AAAA);
        check("wrap_w1", mem[8'h01], 32'hBBBB_BBBB);

        // Abort in cycle 3 of a ten-word copy.
        run_copy(10'h040, 10'h300, 10, 3, 0);
        for (int i = 0; i < 3; i++) check("abort_copied", mem[8'hC0 + i], 32'h5000_0000 + i);
        for (int i = 3; i < 10; i++) check("abort_untouched", mem[8'hC0 + i], 32'hDEAD_00C0 + i);

        // Reset in cycle 3 of an eight-word copy, then a normal copy.
        run_copy(10'h040, 10'h200, 8, 0, 3);
        run_copy(10'h040, 10'h280, 3, 0, 0);
        for (int i = 0; i < 3; i++) check("after_rst", mem[8'hA0 + i], 32'h5000_0000 + i);

        repeat (2) @(posedge g_clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
      end
    join_any
  end

endmodule
